// File: rtl/prover_buf_pkg.sv
// Shared constants and helpers for the double-banked prover round buffer.
`ifndef F_NBITS
`define F_NBITS 61
`endif

package prover_buf_pkg;

  localparam int F_NBITS_DEF = `F_NBITS;
  localparam int CODE_W      = 2;

  typedef logic [1:0] occ_t;
  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // Counter width able to hold 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prover_round_bank.sv
// One round bank: nwords-deep word store with count/code, clear-on-open
// and a read port that masks words at or beyond the stored count.
module prover_round_bank
  import prover_buf_pkg::*;
#(
  parameter int nbits   = F_NBITS_DEF,
  parameter int nwords  = 5,
  parameter int cntbits = clog2p1(nwords)
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          wr_en_i,
  input  logic [cntbits-1:0]            wr_idx_i,
  input  logic [nbits-1:0]              wr_data_i,
  input  logic                          clr_i,
  input  logic                          load_i,
  input  logic [cntbits-1:0]            count_i,
  input  logic [CODE_W-1:0]             code_i,
  output logic [nwords-1:0][nbits-1:0]  data_o,
  output logic [cntbits-1:0]            count_o,
  output logic [CODE_W-1:0]             code_o
);

  logic [cntbits-1:0] count_q;
  logic [CODE_W-1:0]  code_q;

  generate
    for (genvar gi = 0; gi < nwords; gi++) begin : g_word
      logic [nbits-1:0] word_q;

      always_ff @(posedge clk) begin
        if (rstb || clr_i) begin
          word_q <= '0;
        end else if (wr_en_i && (wr_idx_i == cntbits'(gi))) begin
          word_q <= wr_data_i;
        end
      end

      assign data_o[gi] = (cntbits'(gi) < count_q) ? word_q : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rstb) begin
      count_q <= '0;
      code_q  <= '0;
    end else if (load_i) begin
      count_q <= count_i;
      code_q  <= code_i;
    end
  end

  assign count_o = count_q;
  assign code_o  = code_q;

endmodule

// File: rtl/prover_round_buffer.sv
// Two-bank round buffer between prover_layer and verifier_interface: the
// prover fills one bank while the verifier drains the other in commit order.
module prover_round_buffer
  import prover_buf_pkg::*;
#(
  parameter int nbits   = F_NBITS_DEF,
  parameter int nwords  = 5,
  parameter int cntbits = clog2p1(nwords)
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          wr_en,
  input  logic [nbits-1:0]              wr_data,
  input  logic                          commit,
  input  logic [CODE_W-1:0]             commit_code,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [nwords-1:0][nbits-1:0]  out_data,
  output logic [cntbits-1:0]            out_count,
  output logic [CODE_W-1:0]             out_code,
  output logic                          overflow
);

  occ_t               occ_q, occ_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [cntbits-1:0] wr_cnt_q, wr_cnt_d;
  logic               ovf_q, ovf_d;

  logic               pop, wr_ok, commit_ok, clr_other, clr_reopen;
  logic [cntbits-1:0] commit_count;

  logic [nwords-1:0][nbits-1:0] bank_data  [2];
  logic [cntbits-1:0]           bank_count [2];
  logic [CODE_W-1:0]            bank_code  [2];

  assign out_valid = (occ_q != OCC_EMPTY);
  assign in_ready  = (occ_q != OCC_FULL);
  assign overflow  = ovf_q;

  assign pop          = out_valid & out_ready;
  assign wr_ok        = wr_en & (occ_q != OCC_FULL) & (wr_cnt_q < cntbits'(nwords));
  assign commit_ok    = commit & ((occ_q != OCC_FULL) | pop);
  assign commit_count = wr_cnt_q + cntbits'(wr_ok);

  always_comb begin
    occ_d = occ_q;
    case ({commit_ok, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    wr_sel_d = wr_sel_q ^ commit_ok;
    rd_sel_d = rd_sel_q ^ pop;
    wr_cnt_d = commit_ok ? '0 : (wr_cnt_q + cntbits'(wr_ok));
    ovf_d    = ovf_q | (wr_en & ~wr_ok) | (commit & ~commit_ok);
  end

  // The next write bank is only wiped once it no longer holds an unread
  // record; a full buffer reopens its write bank when that bank is popped.
  assign clr_other  = commit_ok & (occ_d != OCC_FULL);
  assign clr_reopen = pop & ~commit_ok & (occ_q == OCC_FULL);

  always_ff @(posedge clk) begin
    if (rstb) begin
      occ_q    <= OCC_EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic is_wr, is_rd;
      assign is_wr = (wr_sel_q == 1'(gi));
      assign is_rd = (rd_sel_q == 1'(gi));

      prover_round_bank #(
        .nbits   (nbits),
        .nwords  (nwords),
        .cntbits (cntbits)
      ) u_bank (
        .clk       (clk),
        .rstb      (rstb),
        .wr_en_i   (wr_ok & is_wr),
        .wr_idx_i  (wr_cnt_q),
        .wr_data_i (wr_data),
        .clr_i     ((clr_other & ~is_wr) | (clr_reopen & is_rd)),
        .load_i    (commit_ok & is_wr),
        .count_i   (commit_count),
        .code_i    (commit_code),
        .data_o    (bank_data[gi]),
        .count_o   (bank_count[gi]),
        .code_o    (bank_code[gi])
      );
    end
  endgenerate

  assign out_data  = out_valid ? bank_data[rd_sel_q]  : '0;
  assign out_count = out_valid ? bank_count[rd_sel_q] : '0;
  assign out_code  = out_valid ? bank_code[rd_sel_q]  : '0;

endmodule

// File: tb/tb_prover_round_buffer.sv
// Directed bench for prover_round_buffer (nwords=5, nbits=61).
module tb_prover_round_buffer;

  localparam int NB = 61;
  localparam int NW = 5;
  localparam int CB = 3;

  typedef logic [NW-1:0][NB-1:0] data_t;

  logic          clk = 1'b0;
  logic          rstb;
  logic          wr_en;
  logic [NB-1:0] wr_data;
  logic          commit;
  logic [1:0]    commit_code;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  data_t         out_data;
  logic [CB-1:0] out_count;
  logic [1:0]    out_code;
  logic          overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;

  prover_round_buffer #(.nbits(NB), .nwords(NW)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_code (commit_code),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_code    (out_code),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_data(input string tag, input data_t exp);
    check_cnt++;
    assert (out_data === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, out_data, exp);
  endtask

  task automatic chk_rec(input string tag, input logic ev, input logic [CB-1:0] ecnt,
                         input logic [1:0] ecode, input data_t edata);
    chk({tag, ".valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".count"}, 64'(out_count), 64'(ecnt));
    chk({tag, ".code"},  64'(out_code),  64'(ecode));
    chk_data({tag, ".data"}, edata);
  endtask

  function automatic data_t mk(input logic [NB-1:0] a, input logic [NB-1:0] b,
                               input logic [NB-1:0] c, input logic [NB-1:0] d,
                               input logic [NB-1:0] e);
    data_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  initial begin
    data_t zero;
    zero = '0;
    rstb = 1'b1; wr_en = 1'b0; wr_data = '0; commit = 1'b0; commit_code = 2'd0; out_ready = 1'b0;

    // Reset then idle
    cyc(); cyc();
    rstb = 1'b0;
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    chk("rst.overflow", 64'(overflow), 64'(0));
    chk_rec("rst", 1'b0, 3'd0, 2'd0, zero);
    cyc();
    chk_rec("idle", 1'b0, 3'd0, 2'd0, zero);

    // Basic round
    out_ready = 1'b1;
    wr_en = 1'b1; wr_data = 61'd10; cyc();
    wr_data = 61'd20; cyc();
    wr_data = 61'd30; cyc();
    wr_en = 1'b0; commit = 1'b1; commit_code = 2'd1; cyc();
    commit = 1'b0;
    chk_rec("basic", 1'b1, 3'd3, 2'd1, mk(10, 20, 30, 0, 0));
    cyc();
    chk_rec("basic.popped", 1'b0, 3'd0, 2'd0, zero);
    chk("basic.in_ready", 64'(in_ready), 64'(1));

    // Backpressure and ordering
    out_ready = 1'b0;
    wr_en = 1'b1; wr_data = 61'd1; cyc();
    wr_data = 61'd2; cyc();
    wr_en = 1'b0; commit = 1'b1; commit_code = 2'd0; cyc();
    wr_en = 1'b1; wr_data = 61'd3; commit = 1'b1; commit_code = 2'd2; cyc();
    wr_en = 1'b0; commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.in_ready", 64'(in_ready), 64'(0));
      chk_rec("bp.hold_A", 1'b1, 3'd2, 2'd0, mk(1, 2, 0, 0, 0));
      cyc();
    end
    out_ready = 1'b1;
    chk_rec("bp.A", 1'b1, 3'd2, 2'd0, mk(1, 2, 0, 0, 0));
    cyc();
    chk_rec("bp.B", 1'b1, 3'd1, 2'd2, mk(3, 0, 0, 0, 0));
    chk("bp.in_ready_after_A", 64'(in_ready), 64'(1));
    cyc();
    chk("bp.empty", 64'(out_valid), 64'(0));
    chk("bp.overflow", 64'(overflow), 64'(0));
    out_ready = 1'b0;

    // Full with coincident pop
    wr_en = 1'b1; wr_data = 61'd7; commit = 1'b1; commit_code = 2'd3; cyc();
    wr_data = 61'd8; commit = 1'b0; cyc();
    wr_en = 1'b0; commit = 1'b1; commit_code = 2'd1; cyc();
    commit = 1'b0;
    chk("full.in_ready", 64'(in_ready), 64'(0));
    chk_rec("full.C", 1'b1, 3'd1, 2'd3, mk(7, 0, 0, 0, 0));
    commit = 1'b1; commit_code = 2'd2; out_ready = 1'b1; cyc();
    commit = 1'b0; out_ready = 1'b0;
    chk("full.pop_commit.in_ready", 64'(in_ready), 64'(0));
    chk("full.pop_commit.overflow", 64'(overflow), 64'(0));
    chk_rec("full.D", 1'b1, 3'd1, 2'd1, mk(8, 0, 0, 0, 0));
    commit = 1'b1; commit_code = 2'd3; cyc();
    commit = 1'b0;
    chk("full.drop.overflow", 64'(overflow), 64'(1));
    chk_rec("full.D_kept", 1'b1, 3'd1, 2'd1, mk(8, 0, 0, 0, 0));
    out_ready = 1'b1; cyc();
    chk_rec("full.E", 1'b1, 3'd0, 2'd2, zero);
    cyc();
    chk("full.drained", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Word overflow
    rstb = 1'b1; cyc();
    rstb = 1'b0;
    chk("wovf.cleared", 64'(overflow), 64'(0));
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = NB'(11 + i); cyc();
    end
    chk("wovf.before", 64'(overflow), 64'(0));
    wr_data = 61'd16; cyc();
    wr_en = 1'b0;
    chk("wovf.flag", 64'(overflow), 64'(1));
    commit = 1'b1; commit_code = 2'd0; cyc();
    commit = 1'b0;
    chk_rec("wovf.rec", 1'b1, 3'd5, 2'd0, mk(11, 12, 13, 14, 15));
    out_ready = 1'b1; cyc();
    out_ready = 1'b0;
    chk("wovf.popped", 64'(out_valid), 64'(0));
    chk("wovf.sticky", 64'(overflow), 64'(1));

    // Reset mid-operation
    wr_en = 1'b1; wr_data = 61'd40; commit = 1'b1; commit_code = 2'd1; cyc();
    commit = 1'b0; wr_data = 61'd41; cyc();
    wr_data = 61'd42; cyc();
    wr_en = 1'b0;
    chk("mid.pending", 64'(out_valid), 64'(1));
    rstb = 1'b1; cyc();
    rstb = 1'b0;
    chk("mid.in_ready", 64'(in_ready), 64'(1));
    chk("mid.overflow", 64'(overflow), 64'(0));
    chk_rec("mid.rst", 1'b0, 3'd0, 2'd0, zero);
    wr_en = 1'b1; wr_data = 61'd99; cyc();
    wr_en = 1'b0; commit = 1'b1; commit_code = 2'd2; cyc();
    commit = 1'b0;
    chk_rec("mid.next", 1'b1, 3'd1, 2'd2, mk(99, 0, 0, 0, 0));
    out_ready = 1'b1; cyc();
    out_ready = 1'b0;
    chk("mid.done", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/prover_round_buffer.md
Name: prover_round_buffer

Overview:
- Collects the field-element words emitted by prover_layer during one sum-check round, whether they are F words (f_wren) or P words (p_wren).
- On the prover's ready_pulse, freezes the collected words, together with the round's ready_code, as one round record.
- Presents each record to verifier_interface over a valid/ready handshake.
- Double-banked, so the prover can begin the next round while the verifier consumes the previous one. Replaces the bare ringbuf_simple between prover_layer and verifier_interface.

Parameters:
- nbits, `F_NBITS: width of one field element.
- nwords, 5: maximum words per round (nhpoints = ninbits+1).
- cntbits, $clog2(nwords+1): width of word counters (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstb  input  1  synchronous reset, active-high (rstb=1 resets on the next posedge).
- wr_en  input  1  write strobe; connect to f_wren|p_wren.
- wr_data  input  nbits  word to write (prover fp_data).
- commit  input  1  end-of-round pulse (prover ready_pulse).
- commit_code  input  2  round code (prover ready_code); captured on accepted commit.
- in_ready  output  1  a bank is open for writing (occupancy<2).
- out_valid  output  1  a committed round is presented.
- out_ready  input  1  consumer accepts the presented round.
- out_data  output  nbits x [nwords-1:0]  round words; index 0 = first word written.
- out_count  output  cntbits  number of valid words in the presented round.
- out_code  output  2  commit_code of the presented round.
- overflow  output  1  sticky error flag; cleared only by reset.

Behaviour:
State:
- Two banks, each holding nwords words, a count and a code.
- wr_sel: bank being filled. rd_sel: oldest committed bank.
- occ in {0,1,2}: number of committed, unconsumed banks. wr_cnt: fill pointer.

Reset:
- occ=0, wr_sel=0, rd_sel=0, wr_cnt=0, overflow=0, all bank words=0.
- Outputs after reset: out_valid=0, in_ready=1, out_count=0, out_code=0, out_data all 0.
- Reset asserted mid-round or mid-handshake discards all rounds, including a round being presented.

Writes:
- If wr_en and occ<2 and wr_cnt<nwords: bank[wr_sel].word[wr_cnt]=wr_data, and wr_cnt increments.
- wr_en when wr_cnt==nwords: word dropped, overflow<=1.
- wr_en when occ==2: word dropped, overflow<=1.

Pop:
- pop = out_valid & out_ready.
- On pop: rd_sel toggles, occ decrements.

Commit:
- A commit is accepted if occ<2, or if occ==2 and pop occurs in the same cycle.
- On acceptance:
  - bank[wr_sel].count = wr_cnt plus any write accepted in the same cycle. A word written in the commit cycle belongs to the committed round.
  - code = commit_code; occ increments (net occ is unchanged if pop coincides).
  - wr_sel toggles; wr_cnt=0.
  - The new write bank's words are zeroed.
- A commit that is not accepted is dropped and sets overflow<=1.
- A commit with wr_cnt==0 is legal and produces a record with count 0.

Output timing and stability:
- out_valid = (occ>0), registered. It asserts on the posedge after the accepted commit (latency 1).
- out_data, out_count and out_code come from bank[rd_sel].
- Words at index >= out_count read as 0.
- All outputs are held stable while out_valid & ~out_ready.
- in_ready = (occ<2), registered.

Ordering:
- Records leave in commit order. The two banks alternate: bank 0, bank 1, bank 0, ...

Decomposition:
- Package prover_buf_pkg holds:
  - localparam for code width (2);
  - the occupancy encoding;
  - function clog2p1(n) for the cntbits derivation.
- One sub-module, prover_round_bank, implements a single bank:
  - nwords x nbits storage plus count/code registers;
  - write port, clear-on-open, and zero-masked read.
- prover_round_buffer instantiates two banks plus the occ/sel/pointer control.

Test Plan (nwords=5, nbits=61):
- Reset then idle: rstb high for 2 cycles -> out_valid=0, in_ready=1, overflow=0, out_data all 0.
- Basic round: write 10,20,30 over 3 cycles, commit with code 2'b01; out_ready=1 -> the next cycle shows out_valid=1, out_data[0..2]=10,20,30, out_data[3..4]=0, out_count=3, out_code=1; pop; then out_valid=0.
- Backpressure and ordering:
  - Setup: hold out_ready=0 throughout.
  - Round A: write 1,2, commit code 0.
  - Round B: write 3, commit code 2, with the word 3 written in the commit cycle.
  - Expected: in_ready=0, and round A is stable for 5 cycles.
  - Then raise out_ready: A is delivered (count 2), then B (count 1, data[0]=3, code 2).
- Full with coincident pop:
  - Setup: occ=2.
  - Stimulus: commit with out_ready=1 in the same cycle.
  - Expected: commit accepted, occ stays 2, overflow=0.
  - Follow-up: commit while occ=2 with out_ready=0 -> overflow=1, records unchanged.
- Word overflow: write 6 words (11..16) then commit -> out_count=5, data=11..15, overflow=1 and it stays 1 until reset.
- Reset mid-operation: one round pending plus 2 words written, then assert rstb -> all outputs return to reset values; the next round of 1 word (99) is delivered with count 1 from bank 0.
